// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and request type constants for mem_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_RESP} state_t;
    localparam logic REQ_READ = 1'b0;
    localparam logic REQ_WRITE = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin winner select, favouring the requester not granted last
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_valid
);
    // a tie goes to the other requester; otherwise the lone valid one wins
    always_comb begin
        any_valid = |valid;
        grant = &valid ? ~last_grant : valid[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache and D-cache line requests onto one memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_type_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [LINE_W-1:0] req_wdata_0,
    output logic              resp_valid_0,
    input  logic              resp_ready_0,
    output logic [LINE_W-1:0] resp_rdata_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_type_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [LINE_W-1:0] req_wdata_1,
    output logic              resp_valid_1,
    input  logic              resp_ready_1,
    output logic [LINE_W-1:0] resp_rdata_1,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_type,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [LINE_W-1:0] mem_resp_rdata,
    output logic              grant_id,
    output logic              busy
);
    state_t state;
    logic   last_grant;
    logic   win;
    logic   any_valid;
    logic   accept;
    logic   sel_ready;

    rr_arb2 u_rr_arb2 (
        .valid      ({req_valid_1, req_valid_0}),
        .last_grant (last_grant),
        .grant      (win),
        .any_valid  (any_valid)
    );

    // handshakes are decoded from state; the response path is a pure pass-through to the granted side
    always_comb begin
        accept = (state == IDLE) && any_valid;
        req_ready_0 = accept && !win;
        req_ready_1 = accept && win;
        mem_req_valid = state == MEM_REQ;
        busy = state != IDLE;
        sel_ready = grant_id ? resp_ready_1 : resp_ready_0;
        mem_resp_ready = (state == MEM_RESP) && sel_ready;
        resp_valid_0 = (state == MEM_RESP) && !grant_id && mem_resp_valid;
        resp_valid_1 = (state == MEM_RESP) && grant_id && mem_resp_valid;
        resp_rdata_0 = mem_resp_rdata;
        resp_rdata_1 = mem_resp_rdata;
    end

    // one outstanding transaction: grant and latch, issue to memory, wait for the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= 1'b1;
            grant_id <= 1'b0;
            mem_req_type <= REQ_READ;
            mem_req_addr <= '0;
            mem_req_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    grant_id <= win;
                    mem_req_type <= win ? req_type_1 : req_type_0;
                    mem_req_addr <= win ? req_addr_1 : req_addr_0;
                    mem_req_wdata <= win ? req_wdata_1 : req_wdata_0;
                    state <= MEM_REQ;
                end
                MEM_REQ: if (mem_req_ready) state <= MEM_RESP;
                MEM_RESP: if (mem_resp_valid && sel_ready) begin
                    last_grant <= grant_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of both requester ports and the memory port.
REQ-002 Parameter LINE_W, default 128, SHALL set the cache line data width on all data ports.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high, on ports clk and rst.
REQ-004 Port list, where x in {0,1}, 0 = I-cache controller and 1 = D-cache controller:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  req_valid_x  in  1  requester x has a memory request
  req_ready_x  out  1  arbiter accepts requester x's request
  req_type_x  in  1  0 = read (refill), 1 = write (write-back)
  req_addr_x  in  ADDR_W  line address
  req_wdata_x  in  LINE_W  write-back line
  resp_valid_x  out  1  response for requester x
  resp_ready_x  in  1  requester x accepts the response
  resp_rdata_x  out  LINE_W  refill line
  mem_req_valid  out  1  request to memory
  mem_req_ready  in  1  memory accepts the request
  mem_req_type  out  1  latched request type
  mem_req_addr  out  ADDR_W  latched address
  mem_req_wdata  out  LINE_W  latched write data
  mem_resp_valid  in  1  memory response valid
  mem_resp_ready  out  1  arbiter accepts the memory response
  mem_resp_rdata  in  LINE_W  memory read data
  grant_id  out  1  index of the current or last granted requester
  busy  out  1  high in any state other than IDLE

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, MEM_REQ and MEM_RESP. Exactly one transaction SHALL be outstanding at a time.
REQ-006 In IDLE, with any req_valid_x high, the winner SHALL be selected as follows:
  - if only one requester is valid, that requester wins;
  - if both are valid, the requester not equal to last_grant wins.
REQ-007 In IDLE, req_ready_x SHALL be high combinationally only for the winner. On that cycle the block SHALL:
  - latch the winner's type, addr and wdata;
  - set grant_id to the winner;
  - move to MEM_REQ.
REQ-008 The loser's req_ready SHALL be 0. Its request SHALL stay pending and SHALL NOT be lost.
REQ-009 In MEM_REQ, mem_req_valid SHALL be 1 and driven from the latched fields.
  - The latched fields SHALL stay stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, the FSM SHALL move to MEM_RESP.
  - Latency from the accept cycle to mem_req_valid SHALL be exactly 1 cycle.
REQ-010 In MEM_RESP, the memory response SHALL pass through combinationally, with g = grant_id:
  - resp_valid_g = mem_resp_valid;
  - resp_rdata_g = mem_resp_rdata;
  - mem_resp_ready = resp_ready_g.
REQ-011 On mem_resp_valid && resp_ready_g, the block SHALL set last_grant to g and return to IDLE.
  - A new request SHALL be accepted no earlier than the following cycle.
REQ-012 Reads and writes SHALL both complete with one memory response. For writes, rdata is don't-care.
REQ-013 Response signals for the non-granted requester SHALL be 0.
  - resp_rdata_x SHALL be driven from mem_resp_rdata on both ports.
REQ-014 Outside MEM_RESP, mem_resp_ready SHALL be 0 and mem_resp_valid SHALL be ignored.
REQ-015 Outside IDLE, both req_ready_x SHALL be 0, whatever the requester inputs.
REQ-016 When both requesters are valid continuously, grants SHALL strictly alternate.

Reset
REQ-017 While rst is high at a clk edge, the block SHALL:
  - set state to IDLE;
  - set last_grant = 1, so requester 0 wins the first tie;
  - set grant_id = 0;
  - clear the latched fields to 0.
REQ-018 After reset, every valid, ready and busy output SHALL be 0 until the first request.
REQ-019 Reset in MEM_REQ or MEM_RESP SHALL abandon the transaction. No response SHALL be forwarded afterwards.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state enum (IDLE, MEM_REQ, MEM_RESP) and the REQ_READ/REQ_WRITE constants.
REQ-021 The winner selection SHALL be a sub-module rr_arb2: inputs valid[1:0] and last_grant, outputs grant and any_valid, purely combinational.

Verification
REQ-022 Single read: only req_valid_0=1 with addr 0x100 -> req_ready_0 for 1 cycle, then mem_req_valid with addr 0x100 and type 0 in the next cycle. mem_resp_valid with rdata 0xA5.. -> resp_valid_0=1 with the same rdata, and busy falls.
REQ-023 Tie after reset: both valid in the same cycle -> requester 0 granted first, requester 1 granted next. Four back-to-back rounds -> grant order 0,1,0,1.
REQ-024 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid and its fields held stable. resp_ready_1=0 for 3 cycles -> mem_resp_ready=0 and the FSM stays in MEM_RESP.
REQ-025 Write-back then refill from requester 1: type 1 with wdata, then type 0 -> two serialized transactions, each with mem_req_type matching.
REQ-026 Reset in MEM_RESP with mem_resp_valid high -> state IDLE next cycle, resp_valid_x=0, and last_grant=1.
REQ-027 Stray mem_resp_valid=1 in IDLE -> mem_resp_ready=0 and no resp_valid_x.
